// File: rtl/regfile_pkg.sv
// Shared types and widths for the register-file write-back path.
package regfile_pkg;
  localparam int REG_ADDR_W = 4;
  localparam int DATA_W     = 32;
  localparam int NUM_REGS   = 16;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] addr;
    logic [DATA_W-1:0]     data;
  } wb_req_t;

  function automatic logic [NUM_REGS-1:0] addrOneHot(input logic [REG_ADDR_W-1:0] a);
    addrOneHot    = '0;
    addrOneHot[a] = 1'b1;
  endfunction
endpackage

// File: rtl/wb_fifo.sv
// Small write-back request FIFO with a per-entry view used to build the pending-write mask.
module wb_fifo
  import regfile_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  flush,
  input  logic                                  push,
  input  logic                                  pop,
  input  wb_req_t                               pushReq,
  output logic                                  full,
  output logic                                  empty,
  output wb_req_t                               head,
  output logic [DEPTH-1:0]                      entryValid,
  output logic [DEPTH-1:0][REG_ADDR_W-1:0]      entryAddr
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  wb_req_t            mem [DEPTH];
  logic [PTR_W-1:0]   wrPtr;
  logic [PTR_W-1:0]   rdPtr;
  logic [CNT_W-1:0]   count;
  logic               doPush;
  logic               doPop;

  assign full   = (count == CNT_W'(DEPTH));
  assign empty  = (count == '0);
  assign doPush = push & ~full & ~flush;
  assign doPop  = pop & ~empty & ~flush;
  assign head   = mem[rdPtr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else if (flush) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (doPush) wrPtr <= wrPtr + PTR_W'(1);
      if (doPop)  rdPtr <= rdPtr + PTR_W'(1);
      case ({doPush, doPop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Payload storage carries no reset; validity comes from the pointers and count.
  always_ff @(posedge clk) begin
    if (doPush) mem[wrPtr] <= pushReq;
  end

  always_comb begin
    logic [PTR_W-1:0] offset;
    offset     = '0;
    entryValid = '0;
    entryAddr  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      offset        = PTR_W'(i) - rdPtr;
      entryValid[i] = ({1'b0, offset} < count);
      entryAddr[i]  = mem[i].addr;
    end
  end
endmodule

// File: rtl/regfile_wb_arbiter.sv
// Arbitrates two buffered write-back sources onto the single registered register-file write port.
module regfile_wb_arbiter
  import regfile_pkg::*;
#(
  parameter int DEPTH   = 2,
  parameter int RR_MODE = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  src0_valid,
  output logic                  src0_ready,
  input  logic [REG_ADDR_W-1:0] src0_addr,
  input  logic [DATA_W-1:0]     src0_data,
  input  logic                  src1_valid,
  output logic                  src1_ready,
  input  logic [REG_ADDR_W-1:0] src1_addr,
  input  logic [DATA_W-1:0]     src1_data,
  output logic                  wb_en,
  output logic [REG_ADDR_W-1:0] wb_addr,
  output logic [DATA_W-1:0]     wb_val,
  output logic [NUM_REGS-1:0]   pending_mask
);
  logic                             full0, full1, empty0, empty1;
  wb_req_t                          head0, head1;
  logic [DEPTH-1:0]                 valid0, valid1;
  logic [DEPTH-1:0][REG_ADDR_W-1:0] addr0, addr1;
  logic                             grant0, grant1;
  logic                             prioSrc1;

  assign src0_ready = ~full0 & ~rst;
  assign src1_ready = ~full1 & ~rst;

  wb_fifo #(.DEPTH(DEPTH)) fifo0 (
    .clk(clk), .rst(rst), .flush(flush),
    .push(src0_valid & src0_ready), .pop(grant0),
    .pushReq('{addr: src0_addr, data: src0_data}),
    .full(full0), .empty(empty0), .head(head0),
    .entryValid(valid0), .entryAddr(addr0)
  );

  wb_fifo #(.DEPTH(DEPTH)) fifo1 (
    .clk(clk), .rst(rst), .flush(flush),
    .push(src1_valid & src1_ready), .pop(grant1),
    .pushReq('{addr: src1_addr, data: src1_data}),
    .full(full1), .empty(empty1), .head(head1),
    .entryValid(valid1), .entryAddr(addr1)
  );

  // Only registered emptiness is consulted, so a same-edge push is never granted.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (!flush) begin
      if (!empty0 && !empty1) begin
        if (RR_MODE == 0 || !prioSrc1) grant0 = 1'b1;
        else                           grant1 = 1'b1;
      end else if (!empty0) begin
        grant0 = 1'b1;
      end else if (!empty1) begin
        grant1 = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prioSrc1 <= 1'b0;
      wb_en    <= 1'b0;
      wb_addr  <= '0;
      wb_val   <= '0;
    end else begin
      wb_en <= grant0 | grant1;
      if (grant0) begin
        prioSrc1 <= 1'b1;
        wb_addr  <= head0.addr;
        wb_val   <= head0.data;
      end else if (grant1) begin
        prioSrc1 <= 1'b0;
        wb_addr  <= head1.addr;
        wb_val   <= head1.data;
      end
    end
  end

  always_comb begin
    pending_mask = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid0[i]) pending_mask |= addrOneHot(addr0[i]);
      if (valid1[i]) pending_mask |= addrOneHot(addr1[i]);
    end
    if (wb_en) pending_mask |= addrOneHot(wb_addr);
  end
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: fixed-priority instance A and round-robin instance B share stimulus.
module tb_regfile_wb_arbiter;
  import regfile_pkg::*;

  logic        clk = 1'b0;
  logic        rst, flush;
  logic        s0v, s1v;
  logic [3:0]  s0a, s1a;
  logic [31:0] s0d, s1d;
  logic        aReady0, aReady1, aWbEn, bReady0, bReady1, bWbEn;
  logic [3:0]  aWbAddr, bWbAddr;
  logic [31:0] aWbVal, bWbVal;
  logic [15:0] aMask, bMask;

  regfile_wb_arbiter #(.DEPTH(2), .RR_MODE(0)) dutA (
    .clk(clk), .rst(rst), .flush(flush),
    .src0_valid(s0v), .src0_ready(aReady0), .src0_addr(s0a), .src0_data(s0d),
    .src1_valid(s1v), .src1_ready(aReady1), .src1_addr(s1a), .src1_data(s1d),
    .wb_en(aWbEn), .wb_addr(aWbAddr), .wb_val(aWbVal), .pending_mask(aMask)
  );

  regfile_wb_arbiter #(.DEPTH(2), .RR_MODE(1)) dutB (
    .clk(clk), .rst(rst), .flush(flush),
    .src0_valid(s0v), .src0_ready(bReady0), .src0_addr(s0a), .src0_data(s0d),
    .src1_valid(s1v), .src1_ready(bReady1), .src1_addr(s1a), .src1_data(s1d),
    .wb_en(bWbEn), .wb_addr(bWbAddr), .wb_val(bWbVal), .pending_mask(bMask)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          src;
    logic [3:0]  addr;
    logic [31:0] data;
    logic [15:0] expMask;
  } vec_t;

  vec_t        vecs[5];
  int          total = 0;
  int          bad = 0;
  logic [35:0] qA0[$], qA1[$], qB0[$], qB1[$];
  bit          logA[$], logB[$];
  logic [31:0] rfA[16], rfB[16];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic resetDut();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    #1;
  endtask

  initial begin
    int j, i0, i1;
    bit acc0, acc1;
    bit expR1[4] = '{1'b1, 1'b1, 1'b0, 1'b0};
    bit expSeq3[6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};

    for (int k = 0; k < 16; k++) begin
      rfA[k] = '0;
      rfB[k] = '0;
    end
    rst = 1'b1; flush = 1'b0;
    s0v = 1'b0; s0a = '0; s0d = '0;
    s1v = 1'b0; s1a = '0; s1d = '0;

    // Write-back scoreboard: source id travels in data bit 31.
    fork
      forever begin
        @(negedge clk);
        if (rst) begin
          qA0.delete(); qA1.delete(); qB0.delete(); qB1.delete();
        end else begin
          if (aWbEn) begin
            rfA[aWbAddr] = aWbVal;
            logA.push_back(aWbVal[31]);
            if (aWbVal[31] ? (qA1.size() == 0) : (qA0.size() == 0)) begin
              total++; bad++;
              $display("FAIL sbA_unexpected: got r%0d=%h required no write", aWbAddr, aWbVal);
            end else if (aWbVal[31]) chk("sbA_src1", {28'd0, aWbAddr, aWbVal}, {28'd0, qA1.pop_front()});
            else                     chk("sbA_src0", {28'd0, aWbAddr, aWbVal}, {28'd0, qA0.pop_front()});
          end
          if (bWbEn) begin
            rfB[bWbAddr] = bWbVal;
            logB.push_back(bWbVal[31]);
            if (bWbVal[31] ? (qB1.size() == 0) : (qB0.size() == 0)) begin
              total++; bad++;
              $display("FAIL sbB_unexpected: got r%0d=%h required no write", bWbAddr, bWbVal);
            end else if (bWbVal[31]) chk("sbB_src1", {28'd0, bWbAddr, bWbVal}, {28'd0, qB1.pop_front()});
            else                     chk("sbB_src0", {28'd0, bWbAddr, bWbVal}, {28'd0, qB0.pop_front()});
          end
          if (flush) begin
            qA0.delete(); qA1.delete(); qB0.delete(); qB1.delete();
          end else begin
            if (s0v && aReady0) qA0.push_back({s0a, s0d});
            if (s1v && aReady1) qA1.push_back({s1a, s1d});
            if (s0v && bReady0) qB0.push_back({s0a, s0d});
            if (s1v && bReady1) qB1.push_back({s1a, s1d});
          end
        end
      end
      begin
        #200000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1, "timeout");
      end
    join_none

    // Reset values
    #1;
    chk("rst_wben", aWbEn, 0);
    chk("rst_mask", aMask, 0);
    chk("rst_ready0", aReady0, 0);
    chk("rst_ready1", bReady1, 0);
    step();
    rst = 1'b0;
    #1;
    chk("rel_ready0", aReady0, 1);
    chk("rel_ready1", aReady1, 1);

    // Test 1: reset with two queued writes
    s0v = 1'b1; s0a = 4'd1; s0d = 32'h0000_1111;
    s1v = 1'b1; s1a = 4'd2; s1d = 32'h8000_2222;
    step();
    s0v = 1'b0; s1v = 1'b0;
    chk("t1_mask_queued", aMask, 16'h0006);
    rst = 1'b1;
    #1;
    chk("t1_rst_wben", aWbEn, 0);
    chk("t1_rst_mask", aMask, 0);
    chk("t1_rst_ready0", aReady0, 0);
    chk("t1_rst_ready1", aReady1, 0);
    step();
    step();
    rst = 1'b0;
    #1;
    chk("t1_rel_ready0", aReady0, 1);
    chk("t1_rel_ready1", aReady1, 1);
    repeat (3) step();
    chk("t1_no_write", aWbEn, 0);

    // Test 2: single-source table
    vecs[0] = '{1'b1, 4'd3,  32'hDEAD_BEEF, 16'h0008};
    vecs[1] = '{1'b0, 4'd0,  32'h0000_0001, 16'h0001};
    vecs[2] = '{1'b0, 4'd15, 32'h7FFF_FFFF, 16'h8000};
    vecs[3] = '{1'b1, 4'd9,  32'h8000_1234, 16'h0200};
    vecs[4] = '{1'b1, 4'd0,  32'hC0FF_EE00, 16'h0001};
    for (int i = 0; i < 5; i++) begin
      if (vecs[i].src) begin
        s1v = 1'b1; s1a = vecs[i].addr; s1d = vecs[i].data;
      end else begin
        s0v = 1'b1; s0a = vecs[i].addr; s0d = vecs[i].data;
      end
      step();
      s0v = 1'b0; s1v = 1'b0;
      chk("t2_mask_queued", aMask, vecs[i].expMask);
      chk("t2_no_bypass", aWbEn, 0);
      step();
      chk("t2_wben", aWbEn, 1);
      chk("t2_addr", aWbAddr, vecs[i].addr);
      chk("t2_val", aWbVal, vecs[i].data);
      chk("t2_mask_out", aMask, vecs[i].expMask);
      step();
      chk("t2_regfile", rfA[vecs[i].addr], vecs[i].data);
      chk("t2_idle", aWbEn, 0);
      chk("t2_mask_clear", aMask, 0);
    end

    // Test 3: fixed-priority contention
    logA.delete();
    j = 0;
    for (int i = 0; i < 4; i++) begin
      chk("t3_ready1", aReady1, expR1[i]);
      chk("t3_ready0", aReady0, 1);
      acc1 = aReady1;
      s0v = 1'b1; s0a = 4'(i + 1); s0d = 32'h0000_0A00 + 32'(i);
      s1v = 1'b1; s1a = 4'(8 + j); s1d = 32'h8000_0B00 + 32'(j);
      step();
      if (acc1) j++;
    end
    s0v = 1'b0; s1v = 1'b0;
    repeat (6) step();
    chk("t3_src1_accepts", j, 2);
    chk("t3_grants", logA.size(), 6);
    for (int k = 0; k < 6 && k < logA.size(); k++) chk("t3_order", logA[k], expSeq3[k]);

    // Test 4: round-robin alternation
    resetDut();
    logB.delete();
    i0 = 0; i1 = 0;
    for (int i = 0; i < 4; i++) begin
      acc0 = bReady0; acc1 = bReady1;
      s0v = 1'b1; s0a = 4'd4; s0d = 32'h0000_0C00 + 32'(i0);
      s1v = 1'b1; s1a = 4'd6; s1d = 32'h8000_0D00 + 32'(i1);
      step();
      if (acc0) i0++;
      if (acc1) i1++;
    end
    s0v = 1'b0; s1v = 1'b0;
    repeat (8) step();
    chk("t4_src0_accepts", i0, 3);
    chk("t4_src1_accepts", i1, 3);
    chk("t4_grants", logB.size(), 6);
    for (int k = 0; k < 6 && k < logB.size(); k++) chk("t4_alternate", logB[k], k % 2);

    // Test 5: src0 held full under round-robin, pointers wrap many times
    resetDut();
    i0 = 0; i1 = 0;
    for (int i = 0; i < 12; i++) begin
      chk("t5_ready0", bReady0, (i < 3) ? 1 : ((i % 2) ? 0 : 1));
      acc0 = bReady0; acc1 = bReady1;
      s0v = 1'b1; s0a = 4'(i0); s0d = 32'h0000_5000 + 32'(i0);
      s1v = 1'b1; s1a = 4'(15 - i1); s1d = 32'h8000_6000 + 32'(i1);
      step();
      if (acc0) i0++;
      if (acc1) i1++;
    end
    s0v = 1'b0; s1v = 1'b0;
    repeat (12) step();
    chk("t5_src0_accepts", i0, 7);
    chk("t5_src1_accepts", i1, 7);

    // Test 6: flush with r5/r7 queued; r6 presented during flush is dropped
    rfA[5] = 32'h5A5A_0005;
    rfA[6] = 32'h5A5A_0006;
    rfA[7] = 32'h5A5A_0007;
    s0v = 1'b1; s0a = 4'd5; s0d = 32'h0000_0555;
    s1v = 1'b1; s1a = 4'd7; s1d = 32'h8000_0777;
    step();
    s1v = 1'b0; s0a = 4'd6; s0d = 32'h0000_0666;
    flush = 1'b1;
    chk("t6_mask_queued", aMask, 16'h00A0);
    chk("t6_wben_before", aWbEn, 0);
    step();
    flush = 1'b0; s0v = 1'b0;
    chk("t6_mask_flushed", aMask, 0);
    chk("t6_wben_flushed", aWbEn, 0);
    repeat (4) step();
    chk("t6_mask_later", aMask, 0);
    chk("t6_r5_untouched", rfA[5], 32'h5A5A_0005);
    chk("t6_r6_untouched", rfA[6], 32'h5A5A_0006);
    chk("t6_r7_untouched", rfA[7], 32'h5A5A_0007);

    chk("end_qA0_empty", qA0.size(), 0);
    chk("end_qA1_empty", qA1.size(), 0);
    chk("end_qB0_empty", qB0.size(), 0);
    chk("end_qB1_empty", qB1.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
